// File: rtl/mips_pipe_pkg.sv
// Shared types and helpers for the MIPS pipeline control slice:
// forwarding select codes, ALU_OP encodings and the per-stage control bundle.
package mips_pipe_pkg;

  localparam int unsigned CTRL_ADDR_W  = 5;
  localparam int unsigned CTRL_ALUOP_W = 2;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [CTRL_ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic                    valid;
    logic                    write_reg;
    logic                    mem_to_reg;
    logic                    branch;
    logic                    read_mem;
    logic                    write_mem;
    logic                    alu_src;
    logic [CTRL_ALUOP_W-1:0] alu_op;
    logic [CTRL_ADDR_W-1:0]  rs;
    logic [CTRL_ADDR_W-1:0]  rt;
    logic [CTRL_ADDR_W-1:0]  wr_addr;
  } ctrl_t;

  // A live stage that will write a non-zero register equal to addr.
  function automatic logic writes_to(input ctrl_t s, input logic [CTRL_ADDR_W-1:0] addr);
    return s.valid & s.write_reg & (s.wr_addr != '0) & (s.wr_addr == addr);
  endfunction

  // RAW dependency of the ID instruction on a stage.
  function automatic logic raw_hit(input ctrl_t s,
                                   input logic [CTRL_ADDR_W-1:0] rs,
                                   input logic [CTRL_ADDR_W-1:0] rt,
                                   input logic uses_rt);
    return writes_to(s, rs) | (uses_rt & writes_to(s, rt));
  endfunction

endpackage

// File: rtl/mips_ctrl_stage_reg.sv
// One pipeline control register; a bubble loads an all-zero, side-effect-free bundle.
module mips_ctrl_stage_reg
  import mips_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  bubble_i,
  input  ctrl_t d_i,
  output ctrl_t q_o
);

  ctrl_t stage_q;
  ctrl_t stage_d;

  always_comb begin
    stage_d = d_i;
    if (bubble_i) stage_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stage_q <= '0;
    else      stage_q <= stage_d;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS datapath: carries decoded control
// ID->EX->MEM->WB, detects hazards, drives forwarding, stall, flush and event counters.
module mips_pipe_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = CTRL_ADDR_W,
  parameter int unsigned ALUOP_W    = CTRL_ALUOP_W,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_write_reg,
  input  logic                  id_mem_to_reg,
  input  logic                  id_branch,
  input  logic                  id_read_mem,
  input  logic                  id_write_mem,
  input  logic                  id_dst_reg,
  input  logic                  id_alu_src,
  input  logic [ALUOP_W-1:0]    id_alu_op,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_zero,
  output logic                  ex_alu_src,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  mem_read_mem,
  output logic                  mem_write_mem,
  output logic                  wb_write_reg,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] ex_wr_addr,
  output logic [REG_ADDR_W-1:0] mem_wr_addr,
  output logic [REG_ADDR_W-1:0] wb_wr_addr,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic                  flush,
  output logic                  pc_src,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  ctrl_t id_d;
  ctrl_t ex_q;
  ctrl_t mem_q;
  ctrl_t wb_q;

  logic             mem_zero_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic                   uses_rt;
  logic                   hazard;
  logic [CTRL_ADDR_W-1:0] id_rs_w;
  logic [CTRL_ADDR_W-1:0] id_rt_w;

  // Destination register is resolved here so later stages carry only wr_addr.
  always_comb begin
    id_d            = '0;
    id_d.valid      = id_valid;
    id_d.write_reg  = id_write_reg;
    id_d.mem_to_reg = id_mem_to_reg;
    id_d.branch     = id_branch;
    id_d.read_mem   = id_read_mem;
    id_d.write_mem  = id_write_mem;
    id_d.alu_src    = id_alu_src;
    id_d.alu_op     = CTRL_ALUOP_W'(id_alu_op);
    id_d.rs         = id_rs_w;
    id_d.rt         = id_rt_w;
    id_d.wr_addr    = id_dst_reg ? CTRL_ADDR_W'(id_rd) : id_rt_w;
  end

  assign id_rs_w = CTRL_ADDR_W'(id_rs);
  assign id_rt_w = CTRL_ADDR_W'(id_rt);

  mips_ctrl_stage_reg u_ex_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (stall | flush),
    .d_i      (id_d),
    .q_o      (ex_q)
  );

  mips_ctrl_stage_reg u_mem_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (flush),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  mips_ctrl_stage_reg u_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  // Branch resolves in MEM; the taken branch itself still retires.
  assign pc_src = mem_q.valid & mem_q.branch & mem_zero_q;
  assign flush  = pc_src;

  assign uses_rt = ~id_alu_src | id_write_mem;
  assign stall   = id_valid & ~flush & hazard;

  if (FWD_EN != 0) begin : g_fwd
    function automatic logic [1:0] fwd_sel(input logic [CTRL_ADDR_W-1:0] src);
      if (writes_to(mem_q, src) && !mem_q.read_mem) return FWD_MEM;
      if (writes_to(wb_q, src))                     return FWD_WB;
      return FWD_REG;
    endfunction

    // Only a load in EX cannot be forwarded in time.
    assign hazard = raw_hit(ex_q, id_rs_w, id_rt_w, uses_rt) & ex_q.read_mem;

    always_comb begin
      fwd_a = fwd_sel(ex_q.rs);
      fwd_b = fwd_sel(ex_q.rt);
    end
  end else begin : g_stall_only
    // Register file is write-first, so a WB producer never needs a stall.
    assign hazard = raw_hit(ex_q, id_rs_w, id_rt_w, uses_rt)
                  | raw_hit(mem_q, id_rs_w, id_rt_w, uses_rt);
    assign fwd_a  = FWD_REG;
    assign fwd_b  = FWD_REG;
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_zero_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      mem_zero_q  <= ex_zero;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Stage fields are only meaningful while the stage holds a real instruction.
  assign ex_alu_src    = ex_q.valid & ex_q.alu_src;
  assign ex_alu_op     = ex_q.valid ? ALUOP_W'(ex_q.alu_op) : '0;
  assign ex_wr_addr    = ex_q.valid ? REG_ADDR_W'(ex_q.wr_addr) : '0;
  assign mem_read_mem  = mem_q.valid & mem_q.read_mem;
  assign mem_write_mem = mem_q.valid & mem_q.write_mem;
  assign mem_wr_addr   = mem_q.valid ? REG_ADDR_W'(mem_q.wr_addr) : '0;
  assign wb_write_reg  = wb_q.valid & wb_q.write_reg;
  assign wb_mem_to_reg = wb_q.valid & wb_q.mem_to_reg;
  assign wb_wr_addr    = wb_q.valid ? REG_ADDR_W'(wb_q.wr_addr) : '0;

  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl: one forwarding instance (a_*) and one
// stall-only instance with 2-bit counters (b_*) share the ID-stage stimulus.
module tb_mips_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_write_reg, id_mem_to_reg, id_branch;
  logic       id_read_mem, id_write_mem, id_dst_reg, id_alu_src;
  logic [1:0] id_alu_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero = 1'b0;

  logic       a_ex_alu_src, a_mem_read_mem, a_mem_write_mem, a_wb_write_reg, a_wb_mem_to_reg;
  logic [1:0] a_ex_alu_op, a_fwd_a, a_fwd_b;
  logic [4:0] a_ex_wr_addr, a_mem_wr_addr, a_wb_wr_addr;
  logic       a_stall, a_flush, a_pc_src;
  logic [15:0] a_stall_cnt, a_flush_cnt;

  logic       b_ex_alu_src, b_mem_read_mem, b_mem_write_mem, b_wb_write_reg, b_wb_mem_to_reg;
  logic [1:0] b_ex_alu_op, b_fwd_a, b_fwd_b;
  logic [4:0] b_ex_wr_addr, b_mem_wr_addr, b_wb_wr_addr;
  logic       b_stall, b_flush, b_pc_src;
  logic [1:0] b_stall_cnt, b_flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_pipe_ctrl #(.REG_ADDR_W(5), .ALUOP_W(2), .FWD_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_write_reg(id_write_reg),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_read_mem(id_read_mem),
    .id_write_mem(id_write_mem), .id_dst_reg(id_dst_reg), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_alu_src(a_ex_alu_src), .ex_alu_op(a_ex_alu_op), .mem_read_mem(a_mem_read_mem),
    .mem_write_mem(a_mem_write_mem), .wb_write_reg(a_wb_write_reg),
    .wb_mem_to_reg(a_wb_mem_to_reg), .ex_wr_addr(a_ex_wr_addr), .mem_wr_addr(a_mem_wr_addr),
    .wb_wr_addr(a_wb_wr_addr), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall(a_stall),
    .flush(a_flush), .pc_src(a_pc_src), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  mips_pipe_ctrl #(.REG_ADDR_W(5), .ALUOP_W(2), .FWD_EN(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_write_reg(id_write_reg),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_read_mem(id_read_mem),
    .id_write_mem(id_write_mem), .id_dst_reg(id_dst_reg), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_alu_src(b_ex_alu_src), .ex_alu_op(b_ex_alu_op), .mem_read_mem(b_mem_read_mem),
    .mem_write_mem(b_mem_write_mem), .wb_write_reg(b_wb_write_reg),
    .wb_mem_to_reg(b_wb_mem_to_reg), .ex_wr_addr(b_ex_wr_addr), .mem_wr_addr(b_mem_wr_addr),
    .wb_wr_addr(b_wb_wr_addr), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall(b_stall),
    .flush(b_flush), .pc_src(b_pc_src), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID stage, then let combinational outputs settle.
  task automatic set_id(input logic v, input logic wr, input logic m2r, input logic br,
                        input logic rdm, input logic wrm, input logic dst, input logic asrc,
                        input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    id_valid = v; id_write_reg = wr; id_mem_to_reg = m2r; id_branch = br;
    id_read_mem = rdm; id_write_mem = wrm; id_dst_reg = dst; id_alu_src = asrc;
    id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    #1;
  endtask

  task automatic rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_id(1, 1, 0, 0, 0, 0, 1, 0, 2'b10, rs, rt, rd);
  endtask
  task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
    set_id(1, 1, 1, 0, 1, 0, 0, 1, 2'b00, rs, rt, 5'd0);
  endtask
  task automatic sw(input logic [4:0] rt, input logic [4:0] rs);
    set_id(1, 0, 0, 0, 0, 1, 0, 1, 2'b00, rs, rt, 5'd0);
  endtask
  task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
    set_id(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, rs, rt, 5'd0);
  endtask
  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ex_zero = 1'b0;
    nop();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset held, then first instruction after release.
    nop();
    tick();
    tick();
    chk("rst_ex_alu_op", 32'(a_ex_alu_op), 0);
    chk("rst_stall_cnt", 32'(a_stall_cnt), 0);
    rst = 1'b1;
    rtype(5'd3, 5'd1, 5'd2);
    chk("rel_ex_wr_addr", 32'(a_ex_wr_addr), 0);
    chk("rel_stall", 32'(a_stall), 0);
    tick();
    chk("add_ex_alu_op", 32'(a_ex_alu_op), 2);
    chk("add_ex_wr_addr", 32'(a_ex_wr_addr), 3);
    chk("add_ex_alu_src", 32'(a_ex_alu_src), 0);
    rtype(5'd4, 5'd3, 5'd5);
    chk("sub_no_stall", 32'(a_stall), 0);
    tick();
    chk("sub_fwd_a_mem", 32'(a_fwd_a), 2);
    chk("sub_fwd_b", 32'(a_fwd_b), 0);
    chk("add_mem_wr_addr", 32'(a_mem_wr_addr), 3);
    rtype(5'd6, 5'd3, 5'd7);
    chk("or_no_stall", 32'(a_stall), 0);
    tick();
    chk("or_fwd_a_wb", 32'(a_fwd_a), 1);
    chk("or_fwd_b", 32'(a_fwd_b), 0);
    chk("add_wb_wr_addr", 32'(a_wb_wr_addr), 3);
    chk("add_wb_write_reg", 32'(a_wb_write_reg), 1);
    chk("sub_mem_wr_addr", 32'(a_mem_wr_addr), 4);

    // Reset mid-stream clears outputs immediately.
    rst = 1'b0;
    #1;
    chk("mid_rst_ex_alu_op", 32'(a_ex_alu_op), 0);
    chk("mid_rst_mem_wr_addr", 32'(a_mem_wr_addr), 0);
    chk("mid_rst_wb_write_reg", 32'(a_wb_write_reg), 0);
    chk("mid_rst_fwd_a", 32'(a_fwd_a), 0);
    tick();
    rst = 1'b1;
    rtype(5'd8, 5'd1, 5'd2);
    chk("mid_rel_ex_wr_addr", 32'(a_ex_wr_addr), 0);
    tick();
    chk("mid_rel_first_ex", 32'(a_ex_wr_addr), 8);

    // Load-use: one bubble then WB forwarding.
    do_reset();
    lw(5'd2, 5'd1);
    tick();
    rtype(5'd4, 5'd2, 5'd2);
    chk("lu_stall", 32'(a_stall), 1);
    tick();
    rtype(5'd4, 5'd2, 5'd2);
    chk("lu_stall_off", 32'(a_stall), 0);
    chk("lu_bubble_alu_op", 32'(a_ex_alu_op), 0);
    chk("lu_bubble_wr_addr", 32'(a_ex_wr_addr), 0);
    chk("lu_mem_read", 32'(a_mem_read_mem), 1);
    chk("lu_mem_write", 32'(a_mem_write_mem), 0);
    chk("lu_stall_cnt", 32'(a_stall_cnt), 1);
    tick();
    nop();
    chk("lu_ex_wr_addr", 32'(a_ex_wr_addr), 4);
    chk("lu_fwd_a", 32'(a_fwd_a), 1);
    chk("lu_fwd_b", 32'(a_fwd_b), 1);
    chk("lu_wb_m2r", 32'(a_wb_mem_to_reg), 1);
    chk("lu_stall_cnt_hold", 32'(a_stall_cnt), 1);

    // FWD_EN=0: two stalls per dependent pair; 2-bit counter saturates.
    do_reset();
    rtype(5'd3, 5'd1, 5'd2);
    tick();
    rtype(5'd4, 5'd3, 5'd5);
    chk("nf_stall1", 32'(b_stall), 1);
    chk("nf_fwd_a1", 32'(b_fwd_a), 0);
    chk("fw_no_stall", 32'(a_stall), 0);
    tick();
    rtype(5'd4, 5'd3, 5'd5);
    chk("nf_stall2", 32'(b_stall), 1);
    chk("nf_ex_bubble", 32'(b_ex_wr_addr), 0);
    chk("nf_mem_wr_addr", 32'(b_mem_wr_addr), 3);
    tick();
    rtype(5'd4, 5'd3, 5'd5);
    chk("nf_stall3", 32'(b_stall), 0);
    chk("nf_stall_cnt2", 32'(b_stall_cnt), 2);
    chk("nf_fwd_a3", 32'(b_fwd_a), 0);
    tick();
    rtype(5'd5, 5'd1, 5'd2);
    chk("nf_sub_ex", 32'(b_ex_wr_addr), 4);
    chk("nf_fwd_b4", 32'(b_fwd_b), 0);
    chk("nf_stall4", 32'(b_stall), 0);
    tick();
    rtype(5'd6, 5'd5, 5'd5);
    chk("nf_stall5", 32'(b_stall), 1);
    tick();
    rtype(5'd6, 5'd5, 5'd5);
    chk("nf_stall6", 32'(b_stall), 1);
    tick();
    rtype(5'd6, 5'd5, 5'd5);
    chk("nf_stall7", 32'(b_stall), 0);
    chk("nf_stall_cnt_sat", 32'(b_stall_cnt), 3);

    // Taken branch kills the two younger instructions.
    do_reset();
    beq(5'd1, 5'd2);
    tick();
    ex_zero = 1'b1;
    sw(5'd5, 5'd6);
    chk("br_pc_src_ex", 32'(a_pc_src), 0);
    tick();
    ex_zero = 1'b0;
    rtype(5'd7, 5'd1, 5'd2);
    chk("br_pc_src", 32'(a_pc_src), 1);
    chk("br_flush", 32'(a_flush), 1);
    chk("br_stall", 32'(a_stall), 0);
    tick();
    nop();
    chk("br_pc_src_off", 32'(a_pc_src), 0);
    chk("br_mem_write", 32'(a_mem_write_mem), 0);
    chk("br_ex_killed", 32'(a_ex_wr_addr), 0);
    chk("br_wb_write", 32'(a_wb_write_reg), 0);
    chk("br_flush_cnt", 32'(a_flush_cnt), 1);
    tick();
    nop();
    chk("br_wb_write2", 32'(a_wb_write_reg), 0);
    chk("br_mem_write2", 32'(a_mem_write_mem), 0);

    // Not-taken branch.
    beq(5'd1, 5'd2);
    tick();
    nop();
    tick();
    nop();
    chk("nt_pc_src", 32'(a_pc_src), 0);
    chk("nt_flush", 32'(a_flush), 0);
    tick();
    nop();
    chk("nt_flush_cnt", 32'(a_flush_cnt), 1);

    // Register 0 never forwards nor stalls.
    do_reset();
    rtype(5'd0, 5'd1, 5'd2);
    tick();
    rtype(5'd4, 5'd0, 5'd0);
    chk("z_nf_stall", 32'(b_stall), 0);
    tick();
    nop();
    chk("z_fwd_a", 32'(a_fwd_a), 0);
    chk("z_fwd_b", 32'(a_fwd_b), 0);
    lw(5'd0, 5'd1);
    tick();
    rtype(5'd4, 5'd0, 5'd0);
    chk("z_lu_stall", 32'(a_stall), 0);

    // Load-use coinciding with a taken branch: flush wins.
    do_reset();
    beq(5'd1, 5'd2);
    tick();
    ex_zero = 1'b1;
    lw(5'd2, 5'd1);
    tick();
    ex_zero = 1'b0;
    rtype(5'd4, 5'd2, 5'd2);
    chk("bl_flush", 32'(a_flush), 1);
    chk("bl_stall", 32'(a_stall), 0);
    tick();
    nop();
    chk("bl_mem_read", 32'(a_mem_read_mem), 0);
    chk("bl_ex_killed", 32'(a_ex_wr_addr), 0);
    chk("bl_stall_cnt", 32'(a_stall_cnt), 0);
    chk("bl_flush_cnt", 32'(a_flush_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
